// File: rtl/jtopl_pkg.sv
// jtopl_pkg: constants and types shared by the JTOPL channel-register slice.
//   - slot-group geometry (6 slots per group: 3 modulators, then 3 carriers)
//   - rhythm channel indices
//   - channel entry layout and the write-merge helper
//   - write FSM state type
package jtopl_pkg;

  localparam int SLOTS_PER_GRP = 6;
  localparam int CH_PER_GRP    = SLOTS_PER_GRP / 2;

  // Rhythm channels: 6 = BD, 7 = HH/SD, 8 = TOM/CYM
  localparam int RHY_CH_BD     = 6;
  localparam int RHY_CH_HHSD   = 7;
  localparam int RHY_CH_TOMCYM = 8;

  localparam int FNUM_W  = 10;
  localparam int BLOCK_W = 3;
  localparam int FB_W    = 3;
  localparam int PAN_W   = 4;

  // 22-bit channel entry
  typedef struct packed {
    logic               keyon;
    logic [BLOCK_W-1:0] block;
    logic [FNUM_W-1:0]  fnum;
    logic [PAN_W-1:0]   pan;
    logic [FB_W-1:0]    fb;
    logic               con;
  } ch_entry_t;

  typedef enum logic {WR_IDLE, WR_PEND} wr_state_e;

  // Merge a (possibly multi-strobe) register write into an existing entry.
  function automatic ch_entry_t apply_write(input ch_entry_t cur, input logic [7:0] d,
                                            input logic lo, input logic hi, input logic fbc);
    ch_entry_t nxt;
    nxt = cur;
    if (lo) nxt.fnum[7:0] = d;
    if (hi) begin
      nxt.keyon     = d[5];
      nxt.block     = d[4:2];
      nxt.fnum[9:8] = d[1:0];
    end
    if (fbc) begin
      nxt.pan = d[7:4];
      nxt.fb  = d[3:1];
      nxt.con = d[0];
    end
    return nxt;
  endfunction

  // Master channel of 4-op pair i (slave is master + 3).
  function automatic logic [4:0] pair_master(input int i);
    return (i < 3) ? 5'(i) : 5'(i + 6);
  endfunction

endpackage

// File: rtl/jtopl_slot_seq.sv
// jtopl_slot_seq: slot counter and slot decode.
//   clk, rst (async, active-high), cen : clock, reset, slot advance enable
//   slot  : current slot index s (0..2*CH-1)
//   ch    : channel of slot s (3*(s/6) + s%3)
//   op    : 0 = modulator, 1 = carrier ((s%6) >= 3)
//   first : s == 0
// Outputs decode the slot about to be presented; the top registers them.
module jtopl_slot_seq import jtopl_pkg::*; #(
  parameter int CH = 9,
  parameter int SW = $clog2(2*CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [SW-1:0] slot,
  output logic [4:0]    ch,
  output logic          op,
  output logic          first
);

  // s is kept alongside its group (g) and in-group position (r) so no divider is needed.
  logic [SW-1:0] s_reg;
  logic [2:0]    r_reg;
  logic [2:0]    g_reg;
  logic [2:0]    lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
      r_reg <= '0;
      g_reg <= '0;
    end else if (cen) begin
      if (s_reg == SW'(2*CH-1)) begin
        s_reg <= '0;
        r_reg <= '0;
        g_reg <= '0;
      end else begin
        s_reg <= s_reg + SW'(1);
        if (r_reg == 3'(SLOTS_PER_GRP-1)) begin
          r_reg <= '0;
          g_reg <= g_reg + 3'd1;
        end else begin
          r_reg <= r_reg + 3'd1;
        end
      end
    end
  end

  always_comb begin
    op    = (r_reg >= 3'(CH_PER_GRP));
    lane  = op ? (r_reg - 3'(CH_PER_GRP)) : r_reg;
    ch    = 5'(g_reg) * 5'(CH_PER_GRP) + 5'(lane);
    slot  = s_reg;
    first = (s_reg == '0);
  end

endmodule

// File: rtl/jtopl_chreg.sv
// jtopl_chreg: channel-register store and slot sequencer (OPL/OPL2/OPL3).
//   clk, rst (async, active-high), cen (one slot per cen)
//   din, sel_ch, up_fnumlo/up_fnumhi/up_fbcon : register write port
//   busy     : write pending, new strobes ignored
//   en4op    : OPL3 4-op pair enables; rhy_en/rhy_kon : rhythm mode key-ons
//   zero, ch_I, op_I : presented slot; fnum_I, block_I, fb_I, con_I, pan_I,
//   keyon_I, kon_edge_I, pair4_I : stage-I channel data for that slot
module jtopl_chreg import jtopl_pkg::*; #(
  parameter int CH       = 9,
  parameter int OPL_TYPE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic [4:0] sel_ch,
  input  logic       up_fnumlo,
  input  logic       up_fnumhi,
  input  logic       up_fbcon,
  output logic       busy,
  input  logic [5:0] en4op,
  input  logic       rhy_en,
  input  logic [4:0] rhy_kon,
  output logic       zero,
  output logic [4:0] ch_I,
  output logic       op_I,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic [2:0] fb_I,
  output logic       con_I,
  output logic [3:0] pan_I,
  output logic       keyon_I,
  output logic       kon_edge_I,
  output logic       pair4_I
);

  localparam int SLOTS  = 2*CH;
  localparam int SW     = $clog2(SLOTS);
  localparam int CW     = $clog2(CH);
  localparam bit HAS4OP = (OPL_TYPE == 3) && (CH == 18);

  logic [SW-1:0] cur_slot;
  logic [4:0]    cur_ch;
  logic          cur_op;
  logic          cur_first;

  jtopl_slot_seq #(.CH(CH), .SW(SW)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .slot  (cur_slot),
    .ch    (cur_ch),
    .op    (cur_op),
    .first (cur_first)
  );

  wr_state_e     state;
  logic [7:0]    pend_din;
  logic [4:0]    pend_ch;
  logic          pend_lo, pend_hi, pend_fb;
  ch_entry_t     mem [CH];
  logic [SLOTS-1:0] hist;

  logic          commit;
  ch_entry_t     wr_entry, own, mst;
  logic [4:0]    mst_ch;
  logic          is_pair, is_slave, k_eff, con_eff;

  always_comb begin
    // Commit only on the target's own modulator slot while a write is pending.
    commit   = (state == WR_PEND) && cen && !cur_op && (cur_ch == pend_ch);
    wr_entry = apply_write(mem[pend_ch[CW-1:0]], pend_din, pend_lo, pend_hi, pend_fb);
    // Write-through: the committing slot presents the merged entry.
    own      = commit ? wr_entry : mem[cur_ch[CW-1:0]];
    mst_ch   = cur_ch - 5'd3;
    mst      = mem[mst_ch[CW-1:0]];

    is_pair  = 1'b0;
    is_slave = 1'b0;
    if (HAS4OP) begin
      for (int i = 0; i < 6; i++) begin
        if (en4op[i]) begin
          if (cur_ch == pair_master(i)) is_pair = 1'b1;
          if (cur_ch == pair_master(i) + 5'd3) begin
            is_pair  = 1'b1;
            is_slave = 1'b1;
          end
        end
      end
    end

    k_eff   = is_slave ? mst.keyon : own.keyon;
    con_eff = own.con;
    if (rhy_en) begin
      case (cur_ch)
        5'(RHY_CH_BD):     k_eff = rhy_kon[4];
        5'(RHY_CH_HHSD): begin
          k_eff   = cur_op ? rhy_kon[3] : rhy_kon[0];
          con_eff = 1'b1;
        end
        5'(RHY_CH_TOMCYM): begin
          k_eff   = cur_op ? rhy_kon[1] : rhy_kon[2];
          con_eff = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write handshake: capture in IDLE on any clk, commit in PEND on the target slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WR_IDLE;
      busy     <= 1'b0;
      pend_din <= '0;
      pend_ch  <= '0;
      pend_lo  <= 1'b0;
      pend_hi  <= 1'b0;
      pend_fb  <= 1'b0;
    end else begin
      case (state)
        WR_IDLE: begin
          if ((up_fnumlo || up_fnumhi || up_fbcon) && (sel_ch < 5'(CH))) begin
            state    <= WR_PEND;
            busy     <= 1'b1;
            pend_din <= din;
            pend_ch  <= sel_ch;
            pend_lo  <= up_fnumlo;
            pend_hi  <= up_fnumhi;
            pend_fb  <= up_fbcon;
          end
        end
        WR_PEND: begin
          if (commit) begin
            state <= WR_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[pend_ch[CW-1:0]] <= wr_entry;
    end
  end

  // Stage-I output registers and per-slot key-on history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero       <= 1'b0;
      ch_I       <= '0;
      op_I       <= 1'b0;
      fnum_I     <= '0;
      block_I    <= '0;
      fb_I       <= '0;
      con_I      <= 1'b0;
      pan_I      <= '0;
      keyon_I    <= 1'b0;
      kon_edge_I <= 1'b0;
      pair4_I    <= 1'b0;
      hist       <= '0;
    end else if (cen) begin
      zero           <= cur_first;
      ch_I           <= cur_ch;
      op_I           <= cur_op;
      fnum_I         <= is_slave ? mst.fnum  : own.fnum;
      block_I        <= is_slave ? mst.block : own.block;
      fb_I           <= own.fb;
      con_I          <= con_eff;
      pan_I          <= HAS4OP ? own.pan : '0;
      keyon_I        <= k_eff;
      kon_edge_I     <= k_eff & ~hist[cur_slot];
      hist[cur_slot] <= k_eff;
      pair4_I        <= is_pair;
    end
  end

endmodule

// File: tb/tb_jtopl_chreg.sv
// tb_jtopl_chreg: directed + random bench for jtopl_chreg (CH=18, OPL3).
// A behavioural model (channel arrays, pending-write record, slot index)
// predicts every output after each clock.
module tb_jtopl_chreg;

  logic       clk, rst, cen;
  logic [7:0] din;
  logic [4:0] sel_ch;
  logic       up_fnumlo, up_fnumhi, up_fbcon;
  logic       busy;
  logic [5:0] en4op;
  logic       rhy_en;
  logic [4:0] rhy_kon;
  logic       zero;
  logic [4:0] ch_I;
  logic       op_I;
  logic [9:0] fnum_I;
  logic [2:0] block_I, fb_I;
  logic       con_I;
  logic [3:0] pan_I;
  logic       keyon_I, kon_edge_I, pair4_I;

  jtopl_chreg #(.CH(18), .OPL_TYPE(3)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .sel_ch(sel_ch),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .busy(busy), .en4op(en4op), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .zero(zero), .ch_I(ch_I), .op_I(op_I), .fnum_I(fnum_I), .block_I(block_I),
    .fb_I(fb_I), .con_I(con_I), .pan_I(pan_I), .keyon_I(keyon_I),
    .kon_edge_I(kon_edge_I), .pair4_I(pair4_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ch2_edges = 0;

  // model state
  int m_fnum[18], m_blk[18], m_kon[18], m_pan[18], m_fb[18], m_con[18];
  bit m_hist[36];
  int m_s;
  bit m_pend, m_lo, m_hi, m_fbw;
  int m_din, m_sel;
  // model expectations
  logic       e_zero, e_op, e_con, e_keyon, e_edge, e_pair;
  logic [4:0] e_ch;
  logic [9:0] e_fnum;
  logic [2:0] e_block, e_fb;
  logic [3:0] e_pan;

  function automatic logic [31:0] dut_vec();
    return {busy, zero, ch_I, op_I, fnum_I, block_I, fb_I, con_I, pan_I, keyon_I, kon_edge_I, pair4_I};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {m_pend, e_zero, e_ch, e_op, e_fnum, e_block, e_fb, e_con, e_pan, e_keyon, e_edge, e_pair};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 18; i++) begin
      m_fnum[i] = 0; m_blk[i] = 0; m_kon[i] = 0; m_pan[i] = 0; m_fb[i] = 0; m_con[i] = 0;
    end
    for (int i = 0; i < 36; i++) m_hist[i] = 0;
    m_s = 0; m_pend = 0; m_lo = 0; m_hi = 0; m_fbw = 0; m_din = 0; m_sel = 0;
    e_zero = 0; e_op = 0; e_con = 0; e_keyon = 0; e_edge = 0; e_pair = 0;
    e_ch = 0; e_fnum = 0; e_block = 0; e_fb = 0; e_pan = 0;
  endtask

  // One presented slot: slot decode by arithmetic, pending commit, overrides.
  task automatic model_present(input bit was_pend);
    int p, c, src, m;
    bit o, k, cn, pr;
    p = m_s;
    c = 3 * (p / 6) + p % 3;
    o = (p % 6) >= 3;
    if (was_pend && c == m_sel && !o) begin
      if (m_lo) m_fnum[c] = (m_fnum[c] & 'h300) | m_din;
      if (m_hi) begin
        m_kon[c]  = (m_din >> 5) & 1;
        m_blk[c]  = (m_din >> 2) & 7;
        m_fnum[c] = (m_fnum[c] & 'hFF) | ((m_din & 3) << 8);
      end
      if (m_fbw) begin
        m_pan[c] = m_din >> 4;
        m_fb[c]  = (m_din >> 1) & 7;
        m_con[c] = m_din & 1;
      end
      m_pend = 0;
    end
    src = c; pr = 0;
    for (int i = 0; i < 6; i++) begin
      m = (i < 3) ? i : i + 6;
      if (en4op[i]) begin
        if (c == m) pr = 1;
        if (c == m + 3) begin pr = 1; src = m; end
      end
    end
    k  = m_kon[src] != 0;
    cn = m_con[c] != 0;
    if (rhy_en) begin
      case (c)
        6: k = rhy_kon[4];
        7: begin k = o ? rhy_kon[3] : rhy_kon[0]; cn = 1; end
        8: begin k = o ? rhy_kon[1] : rhy_kon[2]; cn = 1; end
        default: ;
      endcase
    end
    e_edge    = k && !m_hist[p];
    m_hist[p] = k;
    e_zero  = (p == 0);
    e_ch    = 5'(c);
    e_op    = o;
    e_fnum  = 10'(m_fnum[src]);
    e_block = 3'(m_blk[src]);
    e_fb    = 3'(m_fb[c]);
    e_con   = cn;
    e_pan   = 4'(m_pan[c]);
    e_keyon = k;
    e_pair  = pr;
    m_s = (p + 1) % 36;
  endtask

  task automatic step(input bit c, input bit lo, input bit hi, input bit fbw,
                      input logic [7:0] d, input logic [4:0] sel);
    bit was_pend;
    cen = c; up_fnumlo = lo; up_fnumhi = hi; up_fbcon = fbw; din = d; sel_ch = sel;
    @(posedge clk);
    was_pend = m_pend;
    if (!was_pend && (lo || hi || fbw) && int'(sel) < 18) begin
      m_pend = 1; m_lo = lo; m_hi = hi; m_fbw = fbw; m_din = int'(d); m_sel = int'(sel);
    end
    if (c) model_present(was_pend);
    #1;
    up_fnumlo = 0; up_fnumhi = 0; up_fbcon = 0;
    chk("step", dut_vec(), exp_vec());
    if (c && e_ch == 5'd2 && kon_edge_I) ch2_edges++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("reset", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) step(1, 0, 0, 0, 8'h00, 5'd0);
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cen = 0; din = 0; sel_ch = 0;
    up_fnumlo = 0; up_fnumhi = 0; up_fbcon = 0;
    en4op = 0; rhy_en = 0; rhy_kon = 0;
    #2;
    do_reset();

    // Sweep order and zero pulse
    for (int n = 1; n <= 36; n++) begin
      step(1, 0, 0, 0, 8'h00, 5'd0);
      if (n == 1) chk("zero_c1", 32'(zero), 32'd1);
      if (n >= 4 && n <= 6) chk("order", 32'({ch_I, op_I}), 32'({5'(n - 4), 1'b1}));
    end

    // fnumlo write to ch4; strobe also lands on cen 37
    step(1, 1, 0, 0, 8'hA5, 5'd4);
    chk("zero_c37", 32'(zero), 32'd1);
    chk("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && busy; i++) step(1, i == 0, 0, 0, 8'h3C, 5'd4);
    chk("wr_ch4", 32'({busy, ch_I, op_I, fnum_I[7:0]}), 32'({1'b0, 5'd4, 1'b0, 8'hA5}));

    // Out-of-range channel
    step(1, 1, 0, 0, 8'hFF, 5'd20);
    chk("bad_sel", 32'(busy), 32'd0);
    for (int n = 0; n < 36; n++) begin
      step(1, 0, 0, 0, 8'h00, 5'd0);
      if (e_ch == 5'd4) chk("ch4_kept", 32'(fnum_I), 32'h0A5);
    end

    // 4-op pair 0/3
    en4op = 6'b000001;
    step(1, 0, 1, 0, 8'h2D, 5'd0);
    wait_idle("busy_4op");
    for (int n = 0; n < 36; n++) begin
      step(1, 0, 0, 0, 8'h00, 5'd0);
      if (e_ch == 5'd3)
        chk("4op_slave", 32'({keyon_I, block_I, fnum_I[9:8], pair4_I}), 32'({1'b1, 3'd3, 2'd1, 1'b1}));
      if (e_ch == 5'd0) chk("4op_master", 32'(pair4_I), 32'd1);
    end
    en4op = 6'b000000;

    // Rhythm: BD and HH on
    rhy_en = 1'b1; rhy_kon = 5'b10001;
    for (int n = 0; n < 36; n++) begin
      step(1, 0, 0, 0, 8'h00, 5'd0);
      if (e_ch == 5'd6) chk("rhy_bd", 32'(keyon_I), 32'd1);
      if (e_ch == 5'd7) chk("rhy_ch7", 32'({keyon_I, con_I}), 32'({!e_op, 1'b1}));
    end
    rhy_en = 1'b0; rhy_kon = 5'b00000;

    // Key-on edge on ch2
    ch2_edges = 0;
    step(1, 0, 1, 0, 8'h20, 5'd2);
    wait_idle("busy_kon");
    for (int n = 0; n < 108; n++) step(1, 0, 0, 0, 8'h00, 5'd0);
    chk("kon_edges_1", 32'(ch2_edges), 32'd2);
    ch2_edges = 0;
    step(1, 0, 1, 0, 8'h00, 5'd2);
    wait_idle("busy_koff");
    for (int n = 0; n < 36; n++) step(1, 0, 0, 0, 8'h00, 5'd0);
    step(1, 0, 1, 0, 8'h20, 5'd2);
    wait_idle("busy_kon2");
    for (int n = 0; n < 36; n++) step(1, 0, 0, 0, 8'h00, 5'd0);
    chk("kon_edges_2", 32'(ch2_edges), 32'd2);

    // Reset while a write is pending
    step(1, 1, 0, 0, 8'h77, 5'd5);
    step(1, 0, 0, 0, 8'h00, 5'd0);
    do_reset();
    for (int n = 0; n < 36; n++) begin
      step(1, 0, 0, 0, 8'h00, 5'd0);
      if (e_ch == 5'd5) chk("abort_ch5", 32'(fnum_I), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit c, s;
      if ($urandom_range(0, 39) == 0) en4op = 6'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rhy_en  = 1'($urandom);
        rhy_kon = 5'($urandom);
      end
      c = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      step(c, s & 1'($urandom), s & 1'($urandom), s & 1'($urandom),
           8'($urandom), 5'($urandom_range(0, 19)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
